// File: rtl/rdsplit32.sv
// rdsplit32: captures a 32-bit register value on a load strobe and streams it
// out as two 16-bit halves over a valid/ready handshake. Both halves come from
// the same captured value, so the 32-bit read is atomic even when the source
// register changes between the two transfers.
module rdsplit32 #(
  parameter bit HI_FIRST = 1'b1  // 1: bits 31:16 go out first, 0: bits 15:0 first
) (
  input  logic        clk,
  input  logic        resetl,
  input  logic [31:0] d,
  input  logic        ld,
  output logic        busy,
  output logic [15:0] dout,
  output logic        dvalid,
  input  logic        dready,
  output logic        dlast,
  input  logic        flush
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] snap_q, snap_d;
  logic [15:0] dout_q, dout_d;
  logic        dvalid_q, dvalid_d;
  logic        dlast_q, dlast_d;

  // Half presented first, in bus order.
  function automatic logic [15:0] first_half(input logic [31:0] v);
    return HI_FIRST ? v[31:16] : v[15:0];
  endfunction

  // Half presented second, in bus order.
  function automatic logic [15:0] second_half(input logic [31:0] v);
    return HI_FIRST ? v[15:0] : v[31:16];
  endfunction

  // Next-state and registered-output logic. The output registers are loaded
  // with the value belonging to the state being entered, so dout/dvalid/dlast
  // are glitch-free flops and the first half appears one cycle after ld.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    dlast_d  = dlast_q;

    if (flush) begin
      // Abort wins over everything; the held snapshot is simply abandoned.
      state_d  = IDLE;
      dvalid_d = 1'b0;
      dlast_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld) begin
            snap_d   = d;
            state_d  = FIRST;
            dout_d   = first_half(d);
            dvalid_d = 1'b1;
            dlast_d  = 1'b0;
          end
        end
        FIRST: begin
          // ld is ignored here; the requester sees busy and retries.
          if (dready) begin
            state_d = SECOND;
            dout_d  = second_half(snap_q);
            dlast_d = 1'b1;
          end
        end
        SECOND: begin
          if (dready) begin
            if (ld) begin
              // Back-to-back: the next snapshot starts with no idle cycle.
              snap_d   = d;
              state_d  = FIRST;
              dout_d   = first_half(d);
              dvalid_d = 1'b1;
              dlast_d  = 1'b0;
            end else begin
              state_d  = IDLE;
              dvalid_d = 1'b0;
              dlast_d  = 1'b0;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          dvalid_d = 1'b0;
          dlast_d  = 1'b0;
        end
      endcase
    end
  end

  // State, snapshot and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q  <= IDLE;
      snap_q   <= 32'd0;
      dout_q   <= 16'd0;
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      dlast_q  <= dlast_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign dlast  = dlast_q;

endmodule

// File: tb/tb_rdsplit32.sv
// tb_rdsplit32: drives two instances (HI_FIRST=1 and HI_FIRST=0) with the same
// stimulus and compares every output each cycle against a transaction-level
// model: a held 32-bit word plus a count of halves still to deliver.
module tb_rdsplit32;

  logic        clk = 1'b0;
  logic        resetl;
  logic [31:0] d;
  logic        ld;
  logic        dready;
  logic        flush;

  logic [1:0]       busy_s;
  logic [1:0]       dvalid_s;
  logic [1:0]       dlast_s;
  logic [1:0][15:0] dout_s;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, index 0 = HI_FIRST=1, index 1 = HI_FIRST=0.
  int          rem [2];       // halves still to deliver for the held word
  logic [31:0] word [2];      // the word being delivered
  bit          dout_zero [2]; // nothing presented since reset, so dout must be 0

  always #5 clk = ~clk;

  rdsplit32 #(.HI_FIRST(1'b1)) u_hi (
    .clk(clk), .resetl(resetl), .d(d), .ld(ld), .busy(busy_s[0]),
    .dout(dout_s[0]), .dvalid(dvalid_s[0]), .dready(dready),
    .dlast(dlast_s[0]), .flush(flush)
  );

  rdsplit32 #(.HI_FIRST(1'b0)) u_lo (
    .clk(clk), .resetl(resetl), .d(d), .ld(ld), .busy(busy_s[1]),
    .dout(dout_s[1]), .dvalid(dvalid_s[1]), .dready(dready),
    .dlast(dlast_s[1]), .flush(flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0;
      dout_zero[k] = 1'b1;
    end
  endtask

  // One clock edge worth of protocol: what a consumer would observe.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!resetl) begin
        rem[k] = 0;
        dout_zero[k] = 1'b1;
      end else if (flush) begin
        rem[k] = 0;
      end else if (rem[k] == 0) begin
        if (ld) begin word[k] = d; rem[k] = 2; end
      end else if (dready) begin
        if (rem[k] == 1 && ld) begin word[k] = d; rem[k] = 2; end
        else rem[k] = rem[k] - 1;
      end
      if (rem[k] != 0) dout_zero[k] = 1'b0;
    end
  endtask

  function automatic logic [15:0] exp_half(input int k);
    // Index 0 sends the upper half first, index 1 the lower half first.
    bit upper = (rem[k] == 2) ? (k == 0) : (k != 0);
    return upper ? word[k][31:16] : word[k][15:0];
  endfunction

  task automatic check_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      string t = $sformatf("%s[%0d]", tag, k);
      chk({t, ".dvalid"}, {31'd0, dvalid_s[k]}, {31'd0, rem[k] != 0});
      chk({t, ".busy"},   {31'd0, busy_s[k]},   {31'd0, rem[k] != 0});
      chk({t, ".dlast"},  {31'd0, dlast_s[k]},  {31'd0, rem[k] == 1});
      if (rem[k] != 0)
        chk({t, ".dout"}, {16'd0, dout_s[k]}, {16'd0, exp_half(k)});
      else if (dout_zero[k])
        chk({t, ".dout0"}, {16'd0, dout_s[k]}, 32'd0);
    end
    $display("%s: resetl=%b ld=%b d=%h rdy=%b fl=%b | hi v=%b l=%b %h | lo v=%b l=%b %h",
             tag, resetl, ld, d, dready, flush, dvalid_s[0], dlast_s[0], dout_s[0],
             dvalid_s[1], dlast_s[1], dout_s[1]);
  endtask

  // Advance one clock: model follows the edge, outputs checked on the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic drive(input logic [31:0] dv, input logic l, input logic r, input logic f);
    d = dv; ld = l; dready = r; flush = f;
  endtask

  initial begin
    model_reset();
    for (int k = 0; k < 2; k++) word[k] = 32'd0;
    resetl = 1'b0;
    drive(32'd0, 1'b0, 1'b0, 1'b0);

    // 1. reset then idle
    cycle("rst");
    cycle("rst");
    resetl = 1'b1;
    for (int i = 0; i < 5; i++) cycle("idle");

    // 2. basic read, both bus orders at once
    drive(32'h12345678, 1'b1, 1'b1, 1'b0);
    cycle("basic");
    drive(32'h12345678, 1'b0, 1'b1, 1'b0);
    cycle("basic");
    cycle("basic");
    chk("basic.end_hi", {16'd0, dout_s[0]}, 32'h5678);
    chk("basic.end_lo", {16'd0, dout_s[1]}, 32'h1234);

    // 3. atomicity under backpressure; second ld during the stall is ignored
    drive(32'hAAAA5555, 1'b1, 1'b0, 1'b0);
    cycle("stall");
    drive(32'hAAAA5555, 1'b0, 1'b0, 1'b0);
    cycle("stall");
    drive(32'hFFFF0000, 1'b1, 1'b0, 1'b0);
    cycle("stall");
    drive(32'hFFFF0000, 1'b0, 1'b0, 1'b0);
    cycle("stall");
    chk("stall.hold", {16'd0, dout_s[0]}, 32'hAAAA);
    drive(32'hFFFF0000, 1'b0, 1'b1, 1'b0);
    cycle("stall");
    chk("stall.second", {16'd0, dout_s[0]}, 32'h5555);
    cycle("stall");

    // 4. back-to-back snapshots
    drive(32'h00010002, 1'b1, 1'b1, 1'b0);
    cycle("b2b");
    drive(32'h00010002, 1'b0, 1'b1, 1'b0);
    cycle("b2b");
    drive(32'h00030004, 1'b1, 1'b1, 1'b0);
    cycle("b2b");
    chk("b2b.third", {16'd0, dout_s[0]}, 32'h0003);
    drive(32'h00030004, 1'b0, 1'b1, 1'b0);
    cycle("b2b");
    cycle("b2b");

    // 5. flush after the first half
    drive(32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    cycle("flush");
    drive(32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    cycle("flush");
    chk("flush.valid", {31'd0, dvalid_s[0]}, 32'd0);
    drive(32'h11112222, 1'b1, 1'b1, 1'b0);
    cycle("flush");
    drive(32'h11112222, 1'b0, 1'b1, 1'b0);
    cycle("flush");
    cycle("flush");

    // ld and flush on the same edge in IDLE: flush wins
    drive(32'h55667788, 1'b1, 1'b1, 1'b1);
    cycle("ldfl");
    drive(32'h0, 1'b0, 1'b0, 1'b0);

    // 6. asynchronous reset between edges while in FIRST
    drive(32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
    cycle("areset");
    drive(32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
    #2 resetl = 1'b0;
    #1;
    chk("areset.dvalid", {31'd0, dvalid_s[0]}, 32'd0);
    chk("areset.dout",   {16'd0, dout_s[0]},   32'd0);
    chk("areset.busy",   {31'd0, busy_s[1]},   32'd0);
    model_reset();
    cycle("areset");
    resetl = 1'b1;
    for (int i = 0; i < 3; i++) cycle("areset");

    // Randomized traffic, including occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom, ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 60),
            ($urandom_range(0, 99) < 4));
      resetl = ($urandom_range(0, 299) != 0);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
